dpd_path_mux: RTL and testbench

Multi-channel, latency-aligned output stage between the TDNN generator and the DAC stream. It supersedes the fixed combinational bypass/DPD select with three additions: a bypass path aligned to generator latency, a glitch-free linear crossfade between bypass and DPD, and an output FIFO with credit-based backpressure. It sits in the NN clock domain.

---
 rtl/dpd_pkg.sv | 30 +++
 rtl/sync_fifo.sv | 54 +++++
 rtl/dpd_path_mux.sv | 188 ++++++++++++++++++
 tb/tb_dpd_path_mux.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dpd_pkg.sv
// Shared definitions for the DPD output path: mode encoding, lane count and saturation.
package dpd_pkg;

  typedef enum logic [1:0] {
    MODE_BYPASS   = 2'b00,
    MODE_FADE_IN  = 2'b01,
    MODE_DPD      = 2'b10,
    MODE_FADE_OUT = 2'b11
  } mode_t;

  // Each antenna channel carries one I lane and one Q lane.
  function automatic int lanes_of(input int num_ch);
    return 2 * num_ch;
  endfunction

  // Clamp a wide signed value into the range of a signed number of the given width.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] x, input int width);
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (width - 1));
    if (x > max_v) begin
      return max_v;
    end else if (x < min_v) begin
      return min_v;
    end
    return x;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy output.
// The read port shows zero whenever the FIFO is empty.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level == '0);
  assign full    = (level == (AW+1)'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy bookkeeping; reset discards everything stored.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop) begin
        level <= level + (AW+1)'(1);
      end else if (do_pop && !do_push) begin
        level <= level - (AW+1)'(1);
      end
    end
  end

  // Storage array, written on accepted pushes only.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/dpd_path_mux.sv
// Latency-aligned bypass/DPD output stage with linear crossfade and a credit-guarded output FIFO.
module dpd_path_mux
  import dpd_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_CH      = 2,
  parameter int ALIGN_DEPTH = 32,
  parameter int OUT_DEPTH   = 16,
  parameter int XF_LOG2     = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             mode_req,
  input  logic [2*NUM_CH*DATA_WIDTH-1:0]   s_axis_in_data,
  input  logic                             s_axis_in_valid,
  output logic                             s_axis_in_ready,
  input  logic [2*NUM_CH*DATA_WIDTH-1:0]   gen_data,
  input  logic                             gen_valid,
  output logic [2*NUM_CH*DATA_WIDTH-1:0]   m_axis_out_data,
  output logic                             m_axis_out_valid,
  input  logic                             m_axis_out_ready,
  output logic [1:0]                       mode_state,
  output logic                             xfade_active,
  output logic [$clog2(ALIGN_DEPTH):0]     align_level,
  output logic                             err_underflow,
  input  logic                             clr_err
);

  localparam int LANES = lanes_of(NUM_CH);
  localparam int VW    = LANES * DATA_WIDTH;
  localparam int OW    = $clog2(OUT_DEPTH) + 1;
  localparam int AW    = XF_LOG2 + 1;
  localparam int PW    = DATA_WIDTH + XF_LOG2 + 3;
  localparam logic [AW-1:0]      ALPHA_FULL = AW'(1 << XF_LOG2);
  localparam logic [XF_LOG2-1:0] FADE_LAST  = XF_LOG2'((1 << XF_LOG2) - 2);

  mode_t               state;
  mode_t               state_nxt;
  logic [XF_LOG2-1:0]  fade_cnt;
  logic [XF_LOG2-1:0]  fade_cnt_nxt;
  logic [AW-1:0]       alpha;
  logic                align_full;
  logic                align_empty;
  logic                align_push;
  logic                process;
  logic                underflow;
  logic [VW-1:0]       align_rd;
  logic [VW-1:0]       mix_data;
  logic [VW-1:0]       pipe_data;
  logic                pipe_valid;
  logic [OW-1:0]       out_level;
  logic                out_empty;
  logic                out_full;
  logic [31:0]         in_flight;

  // Every sample in the alignment FIFO, the mix register or the output FIFO holds an output slot.
  assign in_flight       = 32'(align_level) + 32'(out_level) + 32'(pipe_valid);
  assign s_axis_in_ready = !rst && !align_full && (in_flight < 32'(OUT_DEPTH));
  assign align_push      = s_axis_in_valid && s_axis_in_ready;
  assign process         = gen_valid && !align_empty;
  assign underflow       = gen_valid && align_empty;

  assign mode_state       = state;
  assign xfade_active     = (state == MODE_FADE_IN) || (state == MODE_FADE_OUT);
  assign m_axis_out_valid = !out_empty;

  sync_fifo #(.WIDTH(VW), .DEPTH(ALIGN_DEPTH)) u_align_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (align_push),
    .wr_data (s_axis_in_data),
    .pop     (gen_valid),
    .rd_data (align_rd),
    .empty   (align_empty),
    .full    (align_full),
    .level   (align_level)
  );

  sync_fifo #(.WIDTH(VW), .DEPTH(OUT_DEPTH)) u_out_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (pipe_valid && !out_full),
    .wr_data (pipe_data),
    .pop     (m_axis_out_ready),
    .rd_data (m_axis_out_data),
    .empty   (out_empty),
    .full    (out_full),
    .level   (out_level)
  );

  // Per lane: y = b + floor((g - b) * alpha / 2^XF_LOG2), clamped to the sample range.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic signed [DATA_WIDTH-1:0] g_s;
    logic signed [DATA_WIDTH-1:0] b_s;
    logic signed [DATA_WIDTH:0]   d;
    logic signed [PW-1:0]         p;
    logic signed [PW-1:0]         p_sh;
    logic signed [PW:0]           y;
    assign g_s  = gen_data[k*DATA_WIDTH +: DATA_WIDTH];
    assign b_s  = align_rd[k*DATA_WIDTH +: DATA_WIDTH];
    assign d    = (DATA_WIDTH+1)'(g_s) - (DATA_WIDTH+1)'(b_s);
    assign p    = PW'(d) * $signed(PW'(alpha));
    assign p_sh = p >>> XF_LOG2;
    assign y    = (PW+1)'(b_s) + (PW+1)'(p_sh);
    assign mix_data[k*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(saturate(64'(y), DATA_WIDTH));
  end

  // Mode state and fade progress advance only on processed generator samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= MODE_BYPASS;
      fade_cnt <= '0;
    end else begin
      state    <= state_nxt;
      fade_cnt <= fade_cnt_nxt;
    end
  end

  // Alpha for the current sample, plus the next mode; a triggering sample still uses the old alpha.
  always_comb begin
    state_nxt    = state;
    fade_cnt_nxt = fade_cnt;
    alpha        = '0;
    case (state)
      MODE_BYPASS:   alpha = '0;
      MODE_FADE_IN:  alpha = AW'(fade_cnt) + AW'(1);
      MODE_DPD:      alpha = ALPHA_FULL;
      MODE_FADE_OUT: alpha = ALPHA_FULL - (AW'(fade_cnt) + AW'(1));
      default:       alpha = '0;
    endcase
    if (process) begin
      case (state)
        MODE_BYPASS: begin
          if (mode_req) begin
            state_nxt    = MODE_FADE_IN;
            fade_cnt_nxt = '0;
          end
        end
        MODE_FADE_IN: begin
          if (fade_cnt == FADE_LAST) begin
            state_nxt    = MODE_DPD;
            fade_cnt_nxt = '0;
          end else begin
            fade_cnt_nxt = fade_cnt + XF_LOG2'(1);
          end
        end
        MODE_DPD: begin
          if (!mode_req) begin
            state_nxt    = MODE_FADE_OUT;
            fade_cnt_nxt = '0;
          end
        end
        MODE_FADE_OUT: begin
          if (fade_cnt == FADE_LAST) begin
            state_nxt    = MODE_BYPASS;
            fade_cnt_nxt = '0;
          end else begin
            fade_cnt_nxt = fade_cnt + XF_LOG2'(1);
          end
        end
        default: state_nxt = MODE_BYPASS;
      endcase
    end
  end

  // Single registered mix stage feeding the output FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_valid <= 1'b0;
      pipe_data  <= '0;
    end else begin
      pipe_valid <= process;
      if (process) pipe_data <= mix_data;
    end
  end

  // Sticky underflow flag; a new underflow outranks a clear in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_underflow <= 1'b0;
    end else if (underflow) begin
      err_underflow <= 1'b1;
    end else if (clr_err) begin
      err_underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dpd_path_mux.sv
// Directed bench for dpd_path_mux: bypass alignment, crossfades, saturation, backpressure, underflow, reset.
module tb_dpd_path_mux;

  localparam int VW = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          mode_req;
  logic [VW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [VW-1:0] gen_data;
  logic          gen_valid;
  logic [VW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [1:0]    mode_state;
  logic          xfade_active;
  logic [5:0]    align_level;
  logic          err_underflow;
  logic          clr_err;

  int            n_checks = 0;
  int            n_pass = 0;
  logic [VW-1:0] got_q[$];
  logic [VW-1:0] g_fade;
  logic [VW-1:0] got;
  logic [VW-1:0] expv;

  always #5 clk = ~clk;

  dpd_path_mux #(
    .DATA_WIDTH(16), .NUM_CH(2), .ALIGN_DEPTH(32), .OUT_DEPTH(16), .XF_LOG2(4)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .mode_req         (mode_req),
    .s_axis_in_data   (in_data),
    .s_axis_in_valid  (in_valid),
    .s_axis_in_ready  (in_ready),
    .gen_data         (gen_data),
    .gen_valid        (gen_valid),
    .m_axis_out_data  (out_data),
    .m_axis_out_valid (out_valid),
    .m_axis_out_ready (out_ready),
    .mode_state       (mode_state),
    .xfade_active     (xfade_active),
    .align_level      (align_level),
    .err_underflow    (err_underflow),
    .clr_err          (clr_err)
  );

  // Record every output beat the DAC side accepts, sampled well after input changes.
  always @(negedge clk) begin
    #2;
    if (!rst && out_valid && out_ready) got_q.push_back(out_data);
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no completion, required finish before timeout");
    $fatal(1);
  end

  function automatic logic [VW-1:0] pack4(input logic [15:0] l0, input logic [15:0] l1,
                                          input logic [15:0] l2, input logic [15:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  // Expected crossfade output for b = 0 and g = g_fade at a given alpha.
  function automatic logic [VW-1:0] exp_scale(input int a);
    return pack4(16'(256 * a), 16'(-256 * a), 16'(512 * a), 16'(128 * a));
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid  = 1'b0;
      gen_valid = 1'b0;
      clr_err   = 1'b0;
    end
  endtask

  // Push n samples and follow each with a generator beat delay cycles later.
  task automatic stream(input int n, input int delay, input logic [VW-1:0] bvec,
                        input logic [VW-1:0] gvec, input bit ramp);
    for (int c = 0; c < n + delay; c++) begin
      @(negedge clk);
      in_valid  = (c < n);
      in_data   = ramp ? bvec + {4{16'(c)}} : bvec;
      gen_valid = (c >= delay);
      gen_data  = gvec;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; gen_valid = 1'b0; clr_err = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; mode_req = 1'b0; in_valid = 1'b0; in_data = '0; gen_valid = 1'b0;
    gen_data = '0; out_ready = 1'b1; clr_err = 1'b0;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b0) $display("[TB] FAIL reset_ready: got %b expected 0", in_ready); else n_pass++;
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== '0)
      $display("[TB] FAIL reset_out: got valid %b data %h expected 0/0", out_valid, out_data);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (mode_state !== 2'b00 || xfade_active !== 1'b0)
      $display("[TB] FAIL reset_mode: got %b/%b expected 00/0", mode_state, xfade_active);
    else n_pass++;
    n_checks++;
    if (align_level !== 6'd0 || err_underflow !== 1'b0)
      $display("[TB] FAIL reset_level_err: got %0d/%b expected 0/0", align_level, err_underflow);
    else n_pass++;
    n_checks++;
    if (in_ready !== 1'b1) $display("[TB] FAIL post_reset_ready: got %b expected 1", in_ready); else n_pass++;
  endtask

  task automatic test_bypass();
    logic [VW-1:0] bbase;
    bbase = pack4(16'h1000, 16'h1100, 16'h1200, 16'h1300);
    mode_req = 1'b0; out_ready = 1'b1; got_q.delete();
    stream(6, 3, bbase, pack4(16'h2000, 16'h2100, 16'h2200, 16'h2300), 1'b1);
    idle(6);
    n_checks++;
    if (got_q.size() !== 6) $display("[TB] FAIL bypass_count: got %0d expected 6", got_q.size()); else n_pass++;
    for (int j = 0; j < 6; j++) begin
      got  = (j < got_q.size()) ? got_q[j] : 'x;
      expv = bbase + {4{16'(j)}};
      n_checks++;
      if (got !== expv) $display("[TB] FAIL bypass[%0d]: got %h expected %h", j, got, expv); else n_pass++;
    end
  endtask

  task automatic test_fade_in();
    int a;
    mode_req = 1'b1; out_ready = 1'b1; got_q.delete();
    stream(5, 1, '0, g_fade, 1'b0);
    idle(2);
    n_checks++;
    if (mode_state !== 2'b01 || xfade_active !== 1'b1)
      $display("[TB] FAIL fade_in_state: got %b/%b expected 01/1", mode_state, xfade_active);
    else n_pass++;
    stream(13, 1, '0, g_fade, 1'b0);
    idle(6);
    for (int j = 0; j < 18; j++) begin
      a    = (j == 0) ? 0 : ((j <= 15) ? j : 16);
      got  = (j < got_q.size()) ? got_q[j] : 'x;
      expv = exp_scale(a);
      n_checks++;
      if (got !== expv) $display("[TB] FAIL fade_in[%0d]: got %h expected %h", j, got, expv); else n_pass++;
    end
    n_checks++;
    if (mode_state !== 2'b10 || xfade_active !== 1'b0)
      $display("[TB] FAIL fade_in_done: got %b/%b expected 10/0", mode_state, xfade_active);
    else n_pass++;
  endtask

  task automatic test_fade_out();
    int a;
    mode_req = 1'b0; got_q.delete();
    stream(18, 1, '0, g_fade, 1'b0);
    idle(6);
    for (int j = 0; j < 18; j++) begin
      a    = (j == 0) ? 16 : ((j <= 15) ? 16 - j : 0);
      got  = (j < got_q.size()) ? got_q[j] : 'x;
      expv = exp_scale(a);
      n_checks++;
      if (got !== expv) $display("[TB] FAIL fade_out[%0d]: got %h expected %h", j, got, expv); else n_pass++;
    end
    n_checks++;
    if (mode_state !== 2'b00) $display("[TB] FAIL fade_out_done: got %b expected 00", mode_state); else n_pass++;
  endtask

  task automatic test_underflow();
    mode_req = 1'b1; got_q.delete();
    stream(3, 1, '0, g_fade, 1'b0);
    idle(4);
    n_checks++;
    if (got_q.size() !== 3 || align_level !== 6'd0)
      $display("[TB] FAIL uf_setup: got %0d outputs level %0d expected 3/0", got_q.size(), align_level);
    else n_pass++;
    @(negedge clk);
    gen_valid = 1'b1; gen_data = g_fade;
    idle(4);
    n_checks++;
    if (err_underflow !== 1'b1) $display("[TB] FAIL uf_flag: got %b expected 1", err_underflow); else n_pass++;
    n_checks++;
    if (got_q.size() !== 3 || mode_state !== 2'b01)
      $display("[TB] FAIL uf_no_output: got %0d outputs mode %b expected 3/01", got_q.size(), mode_state);
    else n_pass++;
    stream(1, 1, '0, g_fade, 1'b0);
    idle(4);
    got = (got_q.size() > 3) ? got_q[3] : 'x;
    n_checks++;
    if (got !== exp_scale(3))
      $display("[TB] FAIL uf_alpha_hold: got %h expected %h", got, exp_scale(3));
    else n_pass++;
    @(negedge clk);
    gen_valid = 1'b1; clr_err = 1'b1;
    idle(1);
    n_checks++;
    if (err_underflow !== 1'b1) $display("[TB] FAIL uf_set_wins: got %b expected 1", err_underflow); else n_pass++;
    @(negedge clk);
    clr_err = 1'b1;
    idle(1);
    n_checks++;
    if (err_underflow !== 1'b0) $display("[TB] FAIL uf_clear: got %b expected 0", err_underflow); else n_pass++;
  endtask

  task automatic test_backpressure();
    int acc;
    logic [VW-1:0] pbase;
    pbase = pack4(16'h0100, 16'h1100, 16'h2100, 16'h3100);
    mode_req = 1'b0;
    apply_reset();
    out_ready = 1'b0; got_q.delete(); acc = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      in_valid  = 1'b1;
      in_data   = pbase + {4{16'(acc)}};
      gen_valid = (c >= 3) && (c < 19);
      gen_data  = pack4(16'h5555, 16'h5555, 16'h5555, 16'h5555);
      #1;
      if (in_ready) acc++;
    end
    idle(1);
    n_checks++;
    if (acc !== 16) $display("[TB] FAIL bp_accepted: got %0d expected 16", acc); else n_pass++;
    n_checks++;
    if (in_ready !== 1'b0) $display("[TB] FAIL bp_ready_low: got %b expected 0", in_ready); else n_pass++;
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== pbase)
      $display("[TB] FAIL bp_head: got %b/%h expected 1/%h", out_valid, out_data, pbase);
    else n_pass++;
    idle(3);
    n_checks++;
    if (out_data !== pbase || got_q.size() !== 0)
      $display("[TB] FAIL bp_hold: got %h with %0d beats expected %h with 0", out_data, got_q.size(), pbase);
    else n_pass++;
    @(negedge clk);
    out_ready = 1'b1;
    idle(20);
    n_checks++;
    if (got_q.size() !== 16) $display("[TB] FAIL bp_drain_count: got %0d expected 16", got_q.size()); else n_pass++;
    for (int j = 0; j < 16; j++) begin
      got  = (j < got_q.size()) ? got_q[j] : 'x;
      expv = pbase + {4{16'(j)}};
      n_checks++;
      if (got !== expv) $display("[TB] FAIL bp_drain[%0d]: got %h expected %h", j, got, expv); else n_pass++;
    end
    n_checks++;
    if (in_ready !== 1'b1) $display("[TB] FAIL bp_ready_back: got %b expected 1", in_ready); else n_pass++;
  endtask

  task automatic test_saturation();
    mode_req = 1'b1; out_ready = 1'b1; got_q.delete();
    stream(16, 1, pack4(16'h7FFF, 16'h8000, 16'h7FFF, 16'h7FFF),
           pack4(16'h7FFF, 16'h7FFF, 16'h8000, 16'h7FFF), 1'b0);
    stream(1, 1, pack4(16'h7FFF, 16'h8000, 16'h7FFF, 16'h7FFF),
           pack4(16'h8000, 16'h7FFF, 16'h7FFF, 16'h7FFF), 1'b0);
    idle(5);
    got  = (got_q.size() > 0) ? got_q[0] : 'x;
    expv = pack4(16'h7FFF, 16'h8000, 16'h7FFF, 16'h7FFF);
    n_checks++;
    if (got !== expv) $display("[TB] FAIL sat_alpha0: got %h expected %h", got, expv); else n_pass++;
    got  = (got_q.size() > 8) ? got_q[8] : 'x;
    expv = pack4(16'h7FFF, 16'hFFFF, 16'hFFFF, 16'h7FFF);
    n_checks++;
    if (got !== expv) $display("[TB] FAIL sat_alpha8: got %h expected %h", got, expv); else n_pass++;
    got  = (got_q.size() > 16) ? got_q[16] : 'x;
    expv = pack4(16'h8000, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    n_checks++;
    if (got !== expv) $display("[TB] FAIL sat_dpd: got %h expected %h", got, expv); else n_pass++;
    n_checks++;
    if (mode_state !== 2'b10) $display("[TB] FAIL sat_mode: got %b expected 10", mode_state); else n_pass++;
  endtask

  task automatic test_reset_mid_fade();
    mode_req = 1'b0; out_ready = 1'b1; got_q.delete();
    stream(3, 1, '0, g_fade, 1'b0);
    idle(4);
    n_checks++;
    if (mode_state !== 2'b11 || xfade_active !== 1'b1 || got_q.size() !== 3)
      $display("[TB] FAIL mid_fade_setup: got %b/%b/%0d expected 11/1/3", mode_state, xfade_active, got_q.size());
    else n_pass++;
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = pack4(16'(c), 16'h0, 16'h0, 16'h0);
    end
    idle(1);
    n_checks++;
    if (align_level !== 6'd5) $display("[TB] FAIL mid_fade_queued: got %0d expected 5", align_level); else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (mode_state !== 2'b00 || align_level !== 6'd0)
      $display("[TB] FAIL mid_reset_state: got %b/%0d expected 00/0", mode_state, align_level);
    else n_pass++;
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || in_ready !== 1'b0)
      $display("[TB] FAIL mid_reset_out: got %b/%h/%b expected 0/0/0", out_valid, out_data, in_ready);
    else n_pass++;
    rst = 1'b0; out_ready = 1'b1;
    idle(4);
    n_checks++;
    if (got_q.size() !== 3 || in_ready !== 1'b1)
      $display("[TB] FAIL mid_reset_flush: got %0d beats ready %b expected 3/1", got_q.size(), in_ready);
    else n_pass++;
  endtask

  initial begin
    g_fade = pack4(16'h1000, 16'hF000, 16'h2000, 16'h0800);
    test_reset();
    test_bypass();
    test_fade_in();
    test_fade_out();
    test_underflow();
    test_backpressure();
    test_saturation();
    test_reset_mid_fade();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
